// File: rtl/jpeg_output_block_sched.sv
// ============================================================================
// jpeg_output_block_sched
// ----------------------------------------------------------------------------
// Steers decoded 8x8 IDCT blocks to the Y store or to the Cb/Cr chroma stores
// following the MCU block order of the latched sampling mode. A block is
// admitted only when its destination store can take all 64 samples. The block
// also sequences the frame: store flush at start, MCU counting, frame done.
//
// Block order per MCU:
//   mono (and reserved mode 3) : Y
//   4:4:4                      : Y, Cb, Cr
//   4:2:0                      : Y, Y, Y, Y, Cb, Cr
//
// Parameters:
//   Y_LEVEL_MAX   Y store capacity in level units
//   CX_BLOCKS     chroma store capacity in blocks
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   start_i                  frame start pulse (honoured in IDLE only)
//   img_mode_i[1:0]          0 mono, 1 4:4:4, 2 4:2:0, 3 reserved (mono)
//   frame_mcus_i[15:0]       MCUs in the frame
//   blk_valid_i/blk_ready_o  IDCT sample handshake
//   blk_idx_i, blk_data_i    sample index / sample word
//   blk_last_i               final sample of the block
//   y_push_o, y_idx_o, y_data_o        registered Y store write
//   cb_push_o, cr_push_o               registered chroma store writes
//   cx_idx_o, cx_data_o                shared chroma write index/data
//   y_level_i, cb_level_i, cr_level_i  store occupancy (used in CHECK only)
//   flush_o                  one-cycle flush to all stores at frame start
//   mode420_o                latched 4:2:0 flag
//   mcu_count_o              completed MCUs of the current frame
//   frame_done_o             one-cycle frame completion pulse
//   stall_cycles_o           CHECK cycles without admission
//
// Optional feature:
//   JPEG_BLOCK_SCHED_PERF_EN  builds the saturating stall cycle counter;
//                             when undefined stall_cycles_o is constant 0.
// ============================================================================
module jpeg_output_block_sched #(
    parameter int unsigned Y_LEVEL_MAX = 256,
    parameter int unsigned CX_BLOCKS   = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    input  logic [1:0]  img_mode_i,
    input  logic [15:0] frame_mcus_i,
    input  logic        blk_valid_i,
    output logic        blk_ready_o,
    input  logic [5:0]  blk_idx_i,
    input  logic [31:0] blk_data_i,
    input  logic        blk_last_i,
    output logic        y_push_o,
    output logic [5:0]  y_idx_o,
    output logic [31:0] y_data_o,
    output logic        cb_push_o,
    output logic        cr_push_o,
    output logic [5:0]  cx_idx_o,
    output logic [31:0] cx_data_o,
    input  logic [31:0] y_level_i,
    input  logic [31:0] cb_level_i,
    input  logic [31:0] cr_level_i,
    output logic        flush_o,
    output logic        mode420_o,
    output logic [15:0] mcu_count_o,
    output logic        frame_done_o,
    output logic [31:0] stall_cycles_o
);

    // ------------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------------
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FLUSH = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_XFER  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [1:0] MODE_MONO = 2'd0;
    localparam logic [1:0] MODE_444  = 2'd1;
    localparam logic [1:0] MODE_420  = 2'd2;

    localparam logic [1:0] DST_Y  = 2'd0;
    localparam logic [1:0] DST_CB = 2'd1;
    localparam logic [1:0] DST_CR = 2'd2;

    // Space limits, evaluated at elaboration in 33-bit arithmetic so that a
    // level near 2^32 can never wrap into an admission.
    localparam logic [32:0] Y_LIMIT      = 33'(Y_LEVEL_MAX);
    localparam logic [32:0] BLK_COST     = 33'd64;
    localparam logic [32:0] CX_COST_420  = 33'd256;
    localparam logic [32:0] CX_LIMIT_STD = 33'(CX_BLOCKS) * BLK_COST;
    localparam logic [32:0] CX_LIMIT_420 = 33'(CX_BLOCKS) * CX_COST_420;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [1:0]  mode_q;
    logic [15:0] frame_mcus_q;
    logic [2:0]  blk_seq_q;
    logic [15:0] mcu_count_q;

    logic [1:0]  cur_dst;
    logic [2:0]  last_seq;
    logic        has_space;
    logic        beat_acc;
    logic        start_acc;
    logic        frame_end;

    logic [32:0] y_need;
    logic [32:0] cx_need;
    logic [32:0] cx_limit;
    logic [31:0] cx_level;

    assign start_acc = (state_q == S_IDLE) && start_i;
    assign beat_acc  = (state_q == S_XFER) && blk_valid_i;
    // The sequence counter has wrapped to 0 and the MCU count caught up with
    // the frame size only after the very last block of the frame.
    assign frame_end = (mcu_count_q == frame_mcus_q) && (blk_seq_q == 3'd0);

    // ------------------------------------------------------------------------
    // Destination of the current block and last block index of the MCU
    // ------------------------------------------------------------------------
    // NOTE: every signal driven here receives a default before the case
    // statements, so no path can leave it unassigned and infer a latch.
    always_comb begin
        cur_dst  = DST_Y;
        last_seq = 3'd0;
        case (mode_q)
            MODE_444: begin
                last_seq = 3'd2;
                case (blk_seq_q)
                    3'd1:    cur_dst = DST_CB;
                    3'd2:    cur_dst = DST_CR;
                    default: cur_dst = DST_Y;
                endcase
            end
            MODE_420: begin
                last_seq = 3'd5;
                case (blk_seq_q)
                    3'd4:    cur_dst = DST_CB;
                    3'd5:    cur_dst = DST_CR;
                    default: cur_dst = DST_Y;
                endcase
            end
            default: begin
                last_seq = 3'd0;
                cur_dst  = DST_Y;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Space check: a chroma block costs a full 256-word quadrant in 4:2:0
    // (the chroma store upsamples it) and a single 64-word quarter otherwise.
    // ------------------------------------------------------------------------
    always_comb begin
        cx_level  = (cur_dst == DST_CB) ? cb_level_i : cr_level_i;
        y_need    = {1'b0, y_level_i} + BLK_COST;
        cx_need   = {1'b0, cx_level} + ((mode_q == MODE_420) ? CX_COST_420 : BLK_COST);
        cx_limit  = (mode_q == MODE_420) ? CX_LIMIT_420 : CX_LIMIT_STD;
        has_space = (cur_dst == DST_Y) ? (y_need <= Y_LIMIT) : (cx_need <= cx_limit);
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_FLUSH;
            S_FLUSH: state_d = (frame_mcus_q == 16'd0) ? S_DONE : S_CHECK;
            S_CHECK: if (has_space) state_d = S_XFER;
            S_XFER:  if (blk_valid_i && blk_last_i) state_d = S_GAP;
            S_GAP:   state_d = frame_end ? S_DONE : S_CHECK;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_MONO;
            frame_mcus_q <= 16'd0;
            blk_seq_q    <= 3'd0;
            mcu_count_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            if (start_acc) begin
                // Reserved mode 3 is folded into mono at latch time so the
                // rest of the block only ever sees three modes.
                mode_q       <= (img_mode_i == 2'd3) ? MODE_MONO : img_mode_i;
                frame_mcus_q <= frame_mcus_i;
                blk_seq_q    <= 3'd0;
                mcu_count_q  <= 16'd0;
            end else if (beat_acc && blk_last_i) begin
                if (blk_seq_q == last_seq) begin
                    blk_seq_q   <= 3'd0;
                    mcu_count_q <= mcu_count_q + 16'd1;
                end else begin
                    blk_seq_q <= blk_seq_q + 3'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registered store writes: a beat accepted in cycle t is written in t+1.
    // Index/data registers only load on a beat for their own store.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            y_push_o  <= 1'b0;
            cb_push_o <= 1'b0;
            cr_push_o <= 1'b0;
            y_idx_o   <= 6'd0;
            y_data_o  <= 32'd0;
            cx_idx_o  <= 6'd0;
            cx_data_o <= 32'd0;
        end else begin
            y_push_o  <= beat_acc && (cur_dst == DST_Y);
            cb_push_o <= beat_acc && (cur_dst == DST_CB);
            cr_push_o <= beat_acc && (cur_dst == DST_CR);
            if (beat_acc && (cur_dst == DST_Y)) begin
                y_idx_o  <= blk_idx_i;
                y_data_o <= blk_data_i;
            end
            if (beat_acc && (cur_dst != DST_Y)) begin
                cx_idx_o  <= blk_idx_i;
                cx_data_o <= blk_data_i;
            end
        end
    end

    // ------------------------------------------------------------------------
    // State-decoded outputs (all decode the registered state, hence 0 in IDLE)
    // ------------------------------------------------------------------------
    assign blk_ready_o  = (state_q == S_XFER);
    assign flush_o      = (state_q == S_FLUSH);
    assign frame_done_o = (state_q == S_DONE);
    assign mode420_o    = (mode_q == MODE_420);
    assign mcu_count_o  = mcu_count_q;

    // ------------------------------------------------------------------------
    // Optional stall cycle counter
    // ------------------------------------------------------------------------
`ifdef JPEG_BLOCK_SCHED_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= 32'd0;
        end else if (start_acc) begin
            stall_q <= 32'd0;
        end else if ((state_q == S_CHECK) && !has_space && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`else
    assign stall_cycles_o = 32'd0;
`endif

endmodule

// File: tb/tb_jpeg_output_block_sched.sv
// ============================================================================
// tb_jpeg_output_block_sched
// ----------------------------------------------------------------------------
// Directed bench for jpeg_output_block_sched. A reference model derives the
// destination of every block from the MCU block order of the mode and queues
// the expected store write for each accepted beat; a monitor compares every
// store write against that queue. Directed checks pin handshake timing,
// stall behaviour, push counts, flush/done pulses and reset behaviour.
// ============================================================================
module tb_jpeg_output_block_sched;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        start_i;
    logic [1:0]  img_mode_i;
    logic [15:0] frame_mcus_i;
    logic        blk_valid_i;
    logic        blk_ready_o;
    logic [5:0]  blk_idx_i;
    logic [31:0] blk_data_i;
    logic        blk_last_i;
    logic        y_push_o;
    logic [5:0]  y_idx_o;
    logic [31:0] y_data_o;
    logic        cb_push_o;
    logic        cr_push_o;
    logic [5:0]  cx_idx_o;
    logic [31:0] cx_data_o;
    logic [31:0] y_level_i;
    logic [31:0] cb_level_i;
    logic [31:0] cr_level_i;
    logic        flush_o;
    logic        mode420_o;
    logic [15:0] mcu_count_o;
    logic        frame_done_o;
    logic [31:0] stall_cycles_o;

    always #5 clk_i = ~clk_i;

    jpeg_output_block_sched dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .start_i        (start_i),
        .img_mode_i     (img_mode_i),
        .frame_mcus_i   (frame_mcus_i),
        .blk_valid_i    (blk_valid_i),
        .blk_ready_o    (blk_ready_o),
        .blk_idx_i      (blk_idx_i),
        .blk_data_i     (blk_data_i),
        .blk_last_i     (blk_last_i),
        .y_push_o       (y_push_o),
        .y_idx_o        (y_idx_o),
        .y_data_o       (y_data_o),
        .cb_push_o      (cb_push_o),
        .cr_push_o      (cr_push_o),
        .cx_idx_o       (cx_idx_o),
        .cx_data_o      (cx_data_o),
        .y_level_i      (y_level_i),
        .cb_level_i     (cb_level_i),
        .cr_level_i     (cr_level_i),
        .flush_o        (flush_o),
        .mode420_o      (mode420_o),
        .mcu_count_o    (mcu_count_o),
        .frame_done_o   (frame_done_o),
        .stall_cycles_o (stall_cycles_o)
    );

    // ------------------------------------------------------------------------
    // Reference model and bookkeeping
    // ------------------------------------------------------------------------
    typedef struct {
        int          dst;   // 0 Y, 1 Cb, 2 Cr
        logic [5:0]  idx;
        logic [31:0] data;
        int          cyc;   // cycle in which the beat is accepted
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   y_cnt, cb_cnt, cr_cnt, flush_cnt, done_cnt;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // MCU block order of each mode, straight from the sampling scheme.
    function automatic int blocks_per_mcu(input int mode);
        case (mode)
            1:       return 3;
            2:       return 6;
            default: return 1;
        endcase
    endfunction

    function automatic int dst_of(input int mode, input int b);
        case (mode)
            1:       return b;                              // Y Cb Cr
            2:       return (b < 4) ? 0 : ((b == 4) ? 1 : 2); // Y Y Y Y Cb Cr
            default: return 0;
        endcase
    endfunction

    // ------------------------------------------------------------------------
    // Monitor: every store write must match the oldest expected beat and
    // appear exactly one cycle after that beat was accepted.
    // ------------------------------------------------------------------------
    always @(negedge clk_i) begin
        int          np;
        int          act_dst;
        exp_t        e;
        if (rst_ni) begin
            np = int'(y_push_o) + int'(cb_push_o) + int'(cr_push_o);
            if (y_push_o)     y_cnt++;
            if (cb_push_o)    cb_cnt++;
            if (cr_push_o)    cr_cnt++;
            if (flush_o)      flush_cnt++;
            if (frame_done_o) done_cnt++;
            if (np != 0) begin
                check("one_push_per_beat", np, 1);
                check("push_has_expected_beat", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    act_dst = y_push_o ? 0 : (cb_push_o ? 1 : 2);
                    check("push_dst", act_dst, e.dst);
                    check("push_idx", y_push_o ? y_idx_o : cx_idx_o, e.idx);
                    check("push_data", y_push_o ? y_data_o : cx_data_o, e.data);
                    check("push_latency", cyc, e.cyc + 1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (all called at posedge + 1)
    // ------------------------------------------------------------------------
    task automatic clear_counts();
        y_cnt = 0; cb_cnt = 0; cr_cnt = 0; flush_cnt = 0; done_cnt = 0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Ends one cycle after start_i was sampled: the DUT is in FLUSH.
    task automatic do_start(input int mode, input int mcus);
        tick();
        img_mode_i   = 2'(mode);
        frame_mcus_i = 16'(mcus);
        start_i      = 1'b1;
        tick();
        start_i      = 1'b0;
        // Changing the mode inputs now proves the DUT latched them at start.
        img_mode_i   = 2'd0;
        frame_mcus_i = 16'd0;
    endtask

    task automatic send_block(input int dst, input int n_beats, input int exp_wait);
        int w;
        exp_t e;
        for (int i = 0; i < n_beats; i++) begin
            blk_valid_i = 1'b1;
            blk_idx_i   = 6'(i);
            blk_data_i  = $urandom;
            blk_last_i  = (i == 63);
            w = 0;
            while (!blk_ready_o && w < 200) begin
                tick();
                w++;
            end
            if (!blk_ready_o) begin
                check("ready_timeout", blk_ready_o, 1);
                blk_valid_i = 1'b0;
                blk_last_i  = 1'b0;
                return;
            end
            if (i == 0 && exp_wait >= 0) check("block_gap_cycles", w, exp_wait);
            e.dst = dst; e.idx = blk_idx_i; e.data = blk_data_i; e.cyc = cyc;
            q.push_back(e);
            tick();
        end
        blk_valid_i = 1'b0;
        blk_last_i  = 1'b0;
    endtask

    // From FLUSH: flush pulse, then CHECK, then XFER (3 cycles after start).
    task automatic check_start_timing();
        check("flush_after_start", flush_o, 1);
        check("ready_in_flush", blk_ready_o, 0);
        tick();
        check("flush_one_cycle", flush_o, 0);
        check("ready_in_check", blk_ready_o, 0);
        tick();
        check("ready_third_cycle", blk_ready_o, 1);
    endtask

    // Called right after the last beat: GAP, then DONE, then IDLE.
    task automatic finish_frame(input int mcus);
        check("ready_in_gap", blk_ready_o, 0);
        check("done_not_in_gap", frame_done_o, 0);
        tick();
        check("frame_done_2_after_last", frame_done_o, 1);
        check("mcu_count", mcu_count_o, mcus);
        tick();
        check("frame_done_one_cycle", frame_done_o, 0);
        check("model_queue_drained", q.size(), 0);
        check("flush_pulses", flush_cnt, 1);
        check("done_pulses", done_cnt, 1);
    endtask

    task automatic run_frame(input int mode, input int mcus);
        clear_counts();
        do_start(mode, mcus);
        check_start_timing();
        check("mode420_latched", mode420_o, mode == 2);
        for (int m = 0; m < mcus; m++)
            for (int b = 0; b < blocks_per_mcu(mode); b++)
                send_block(dst_of(mode, b), 64, (m == 0 && b == 0) ? 0 : 2);
        finish_frame(mcus);
        check("stall_none", stall_cycles_o, 0);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        rst_ni       = 1'b0;
        start_i      = 1'b0;
        img_mode_i   = 2'd0;
        frame_mcus_i = 16'd0;
        blk_valid_i  = 1'b0;
        blk_idx_i    = 6'd0;
        blk_data_i   = 32'd0;
        blk_last_i   = 1'b0;
        y_level_i    = 32'd0;
        cb_level_i   = 32'd0;
        cr_level_i   = 32'd0;
        clear_counts();

        #12;
        check("rst_ready", blk_ready_o, 0);
        check("rst_pushes", {y_push_o, cb_push_o, cr_push_o}, 0);
        check("rst_flush_done", {flush_o, frame_done_o}, 0);
        check("rst_mode420", mode420_o, 0);
        check("rst_mcu_count", mcu_count_o, 0);
        check("rst_stall", stall_cycles_o, 0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Mono, two MCUs: 128 Y pushes, no chroma.
        run_frame(0, 2);
        check("mono_y_pushes", y_cnt, 128);
        check("mono_chroma_pushes", cb_cnt + cr_cnt, 0);

        // 4:2:0, one MCU: 256 Y, 64 Cb, 64 Cr in that order.
        run_frame(2, 1);
        check("420_y_pushes", y_cnt, 256);
        check("420_cb_pushes", cb_cnt, 64);
        check("420_cr_pushes", cr_cnt, 64);
        check("420_mode_held", mode420_o, 1);

        // Reserved mode behaves as mono.
        run_frame(3, 1);
        check("mode3_y_pushes", y_cnt, 64);
        check("mode3_chroma_pushes", cb_cnt + cr_cnt, 0);
        check("mode3_not_420", mode420_o, 0);

        // 4:4:4 with the Y store too full (200 + 64 > 256).
        clear_counts();
        y_level_i = 32'd200;
        do_start(1, 1);
        check("stall_flush", flush_o, 1);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("y_full_no_ready", blk_ready_o, 0);
        end
        y_level_i = 32'd192;   // 192 + 64 == 256: fits exactly
        tick();
        check("y_admit_next_cycle", blk_ready_o, 1);
`ifdef JPEG_BLOCK_SCHED_PERF_EN
        check("y_stall_cycles", stall_cycles_o, 9);
`else
        check("y_stall_cycles_off", stall_cycles_o, 0);
`endif
        y_level_i = 32'd0;
        send_block(0, 64, 0);
        send_block(1, 64, 2);
        send_block(2, 64, 2);
        finish_frame(1);
        check("444_pushes", {y_cnt[15:0], cb_cnt[15:0], cr_cnt[15:0]}, {16'd64, 16'd64, 16'd64});

        // 4:2:0 with Cb store at 769: 769 + 256 > 1024 stalls, 768 fits.
        clear_counts();
        cb_level_i = 32'd769;
        do_start(2, 1);
        check_start_timing();
        for (int b = 0; b < 4; b++) send_block(0, 64, (b == 0) ? 0 : 2);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("cb_full_no_ready", blk_ready_o, 0);
        end
        cb_level_i = 32'd768;
        tick();
        check("cb_admit_next_cycle", blk_ready_o, 1);
`ifdef JPEG_BLOCK_SCHED_PERF_EN
        check("cb_stall_cycles", stall_cycles_o, 5);
`else
        check("cb_stall_cycles_off", stall_cycles_o, 0);
`endif
        cb_level_i = 32'd0;
        send_block(1, 64, 0);
        send_block(2, 64, 2);
        finish_frame(1);
        check("420_stall_cb_pushes", cb_cnt, 64);

        // Empty frame: flush then done, never ready.
        clear_counts();
        do_start(0, 0);
        check("empty_flush", flush_o, 1);
        check("empty_ready0", blk_ready_o, 0);
        tick();
        check("empty_done", frame_done_o, 1);
        check("empty_ready1", blk_ready_o, 0);
        tick();
        check("empty_done_one_cycle", frame_done_o, 0);
        check("empty_ready2", blk_ready_o, 0);
        check("empty_done_pulses", done_cnt, 1);
        check("empty_mcu_count", mcu_count_o, 0);

        // Reset in the middle of a Y block.
        clear_counts();
        do_start(1, 1);
        check_start_timing();
        send_block(0, 10, 0);
        check("pre_reset_push_active", y_push_o, 1);
        #1;
        rst_ni = 1'b0;
        #1;
        check("mid_rst_pushes", {y_push_o, cb_push_o, cr_push_o}, 0);
        check("mid_rst_ready", blk_ready_o, 0);
        check("mid_rst_flush_done", {flush_o, frame_done_o}, 0);
        check("mid_rst_idx_data", {y_idx_o, y_data_o}, 0);
        check("mid_rst_mcu_count", mcu_count_o, 0);
        q.delete();
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        run_frame(0, 1);
        check("post_reset_y_pushes", y_cnt, 64);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", n_checks);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/jpeg_output_block_sched.md
# jpeg_output_block_sched

Block scheduler that sits between the IDCT output and the three output sample stores: the Y store and the Cb/Cr chroma stores. It steers each decoded 8x8 block to the correct store according to the MCU block order of the current sampling mode. It admits a block only when the destination store has room for all of it, and it sequences frame start (store flush), MCU counting and frame completion.

## Interface
Parameters:
- Y_LEVEL_MAX, 256, Y store capacity in level units
- CX_BLOCKS, 4, chroma store capacity in blocks (one 64-word quarter per block)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; asynchronous assert, active-low
- start_i  in  1  frame start pulse, honoured in IDLE only
- img_mode_i  in  2  0=mono, 1=4:4:4, 2=4:2:0, 3=reserved (treated as mono); sampled at start
- frame_mcus_i  in  16  MCUs in frame; sampled at start
- blk_valid_i / blk_ready_o  in/out  1  IDCT sample handshake
- blk_idx_i  in  6  sample index within block
- blk_data_i  in  32  sample word
- blk_last_i  in  1  final sample of block
- y_push_o, y_idx_o[5:0], y_data_o[31:0]  out  Y store write
- cb_push_o, cr_push_o  out  1  chroma store writes
- cx_idx_o[5:0], cx_data_o[31:0]  out  shared chroma write index/data
- y_level_i, cb_level_i, cr_level_i  in  32  store occupancy
- flush_o  out  1  flush to all three stores
- mode420_o  out  1  latched 4:2:0 flag to chroma stores
- mcu_count_o  out  16  completed MCUs
- frame_done_o  out  1  one-cycle pulse
- stall_cycles_o  out  32  see Configuration

## Operation
- States:
  - IDLE -> FLUSH on start_i: latch mode and frame_mcus; clear counters.
  - FLUSH: flush_o=1 for one cycle. Then DONE if frame_mcus==0, else CHECK.
  - CHECK -> XFER when the destination of the current block has space. Otherwise remain in CHECK (stall).
  - XFER: blk_ready_o=1. Each accepted beat is forwarded to the current destination. An accepted beat with blk_last_i=1 advances the block sequence -> GAP.
  - GAP: one idle cycle so the registered push reaches the store level. -> DONE if the last block of the last MCU was sent, else CHECK.
  - DONE: frame_done_o=1 for one cycle -> IDLE.
- Block order per MCU:
  - mono: Y
  - 4:4:4: Y, Cb, Cr
  - 4:2:0: Y, Y, Y, Y, Cb, Cr
- Block sequence counter is 3 bits and wraps to 0 after the last block of the MCU; mcu_count_o increments at that wrap.
- Space rules:
  - Y block admitted when y_level_i + 64 <= Y_LEVEL_MAX.
  - Chroma block admitted when the target level + cost <= CX_BLOCKS*cost, where cost = 256 in 4:2:0 and 64 otherwise. Target is cb_level_i for a Cb block and cr_level_i for a Cr block.
  - Arithmetic is 33-bit; no wrap.
- blk_idx_i is passed through unmodified. Block length is defined solely by blk_last_i; no beat count check.
- mode420_o holds the latched mode from start until the next start.

## Timing
- Push, idx and data outputs are registered: a beat accepted in cycle t appears in cycle t+1. Exactly one of y_push_o, cb_push_o, cr_push_o is high per accepted beat.
- blk_ready_o is a registered function of state only; it does not depend on blk_valid_i.
- Minimum block-to-block gap is 2 cycles of blk_ready_o=0 (GAP, then CHECK).
- Cycles from start_i to first blk_ready_o: 3 (FLUSH, CHECK, XFER).
- Reset values: all outputs 0; state IDLE; mcu_count_o=0; mode420_o=0.
- start_i outside IDLE is ignored. Reset asserted mid-frame returns to IDLE immediately, without a flush pulse.
- Level inputs are sampled only in CHECK.

## Configuration
- JPEG_BLOCK_SCHED_PERF_EN defined:
  - stall_cycles_o counts cycles spent in CHECK without admission.
  - Cleared at start; saturates at 0xFFFFFFFF.
- Undefined: stall_cycles_o is constant 0 and no counter is built.

## Test plan
- Mono, frame_mcus=2, 128 beats, levels 0:
  - flush_o one cycle after start.
  - 128 y_push_o, cb/cr never pulse.
  - mcu_count_o=2, then one frame_done_o.
- 4:2:0, frame_mcus=1, levels 0:
  - 256 y pushes, then 64 cb pushes, then 64 cr pushes.
  - mode420_o=1; frame_done_o 2 cycles after last beat.
- 4:4:4, y_level_i held at 200, Y_LEVEL_MAX=256:
  - blk_ready_o stays 0 in CHECK.
  - Dropping y_level_i to 192 admits the block on the next cycle.
  - With PERF_EN, stall_cycles_o equals the hold cycles.
- 4:2:0 with cb_level_i=769:
  - Cb block stalls.
  - At 768 it is admitted (768+256=1024).
- frame_mcus=0:
  - start -> flush_o -> frame_done_o.
  - No blk_ready_o ever.
- Reset mid-XFER (rst_ni low after 10 Y beats):
  - All outputs 0 asynchronously; state IDLE.
  - A new start_i runs a clean frame.
